// File: rtl/uart_host_loader.sv
// Host side of the UART boot/load protocol: waits for the 0x99 and 0xAA sync bytes,
// streams the program and data images from a byte memory, then captures one result byte.
module uart_host_loader #(
  parameter int PROG_LEN    = 256,
  parameter int DATA_LEN    = 256,
  parameter int PROG_BASE   = 0,
  parameter int DATA_BASE   = 256,
  parameter int ADDR_W      = 16,
  parameter int TIMEOUT_CYC = 50000000
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              start,
  input  logic [7:0]        rx_byte,
  input  logic              rx_valid,
  output logic [7:0]        tx_byte,
  output logic              tx_start,
  input  logic              tx_done,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [7:0]        result,
  output logic              result_valid
);

  localparam int MAX_LEN = (PROG_LEN > DATA_LEN) ? PROG_LEN : DATA_LEN;
  localparam int IDX_W   = $clog2(MAX_LEN + 1);
  localparam int TMO_W   = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

  localparam logic [IDX_W-1:0]  PROG_LAST = IDX_W'(PROG_LEN - 1);
  localparam logic [IDX_W-1:0]  DATA_LAST = IDX_W'(DATA_LEN - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
  localparam logic [ADDR_W-1:0] PROG_ADDR = ADDR_W'(PROG_BASE);
  localparam logic [ADDR_W-1:0] DATA_ADDR = ADDR_W'(DATA_BASE);
  localparam logic [7:0]        SYNC_PROG = 8'h99;
  localparam logic [7:0]        SYNC_DATA = 8'hAA;

  typedef enum logic [3:0] {
    IDLE, W_SYNC1, P_FETCH, P_LOAD, P_SEND, W_SYNC2,
    D_FETCH, D_LOAD, D_SEND, W_RESULT, DONE, ERR
  } state_t;

  state_t            state_reg, state_next;
  logic [IDX_W-1:0]  idx_reg, idx_next;
  logic [TMO_W-1:0]  tmo_reg, tmo_next;
  logic [7:0]        tx_byte_reg, tx_byte_next;
  logic [ADDR_W-1:0] mem_addr_reg, mem_addr_next;
  logic [7:0]        result_reg, result_next;
  logic              result_valid_reg, result_valid_next;
  logic              tmo_expired;

  assign tmo_expired = (TIMEOUT_CYC > 0) && (tmo_reg == TMO_LAST);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_reg        <= IDLE;
      idx_reg          <= '0;
      tmo_reg          <= '0;
      tx_byte_reg      <= '0;
      mem_addr_reg     <= '0;
      result_reg       <= '0;
      result_valid_reg <= 1'b0;
    end else begin
      state_reg        <= state_next;
      idx_reg          <= idx_next;
      tmo_reg          <= tmo_next;
      tx_byte_reg      <= tx_byte_next;
      mem_addr_reg     <= mem_addr_next;
      result_reg       <= result_next;
      result_valid_reg <= result_valid_next;
    end
  end

  // The timeout count defaults to zero, so it restarts on every entry into a wait state.
  always_comb begin
    state_next        = state_reg;
    idx_next          = idx_reg;
    tmo_next          = '0;
    tx_byte_next      = tx_byte_reg;
    mem_addr_next     = mem_addr_reg;
    result_next       = result_reg;
    result_valid_next = 1'b0;
    case (state_reg)
      IDLE, DONE, ERR: begin
        if (start) begin
          state_next = W_SYNC1;
          idx_next   = '0;
        end
      end
      W_SYNC1: begin
        if (rx_valid && rx_byte == SYNC_PROG) begin
          state_next    = P_FETCH;
          idx_next      = '0;
          mem_addr_next = PROG_ADDR;
        end else if (tmo_expired) begin
          state_next = ERR;
        end else begin
          tmo_next = tmo_reg + TMO_W'(1);
        end
      end
      P_FETCH: state_next = P_LOAD;
      P_LOAD: begin
        tx_byte_next = mem_rdata;
        state_next   = P_SEND;
      end
      P_SEND: begin
        if (tx_done) begin
          if (idx_reg == PROG_LAST) begin
            state_next = W_SYNC2;
            idx_next   = '0;
          end else begin
            idx_next      = idx_reg + IDX_W'(1);
            mem_addr_next = mem_addr_reg + ADDR_W'(1);
            state_next    = P_FETCH;
          end
        end
      end
      W_SYNC2: begin
        if (rx_valid && rx_byte == SYNC_DATA) begin
          state_next    = D_FETCH;
          idx_next      = '0;
          mem_addr_next = DATA_ADDR;
        end else if (tmo_expired) begin
          state_next = ERR;
        end else begin
          tmo_next = tmo_reg + TMO_W'(1);
        end
      end
      D_FETCH: state_next = D_LOAD;
      D_LOAD: begin
        tx_byte_next = mem_rdata;
        state_next   = D_SEND;
      end
      D_SEND: begin
        if (tx_done) begin
          if (idx_reg == DATA_LAST) begin
            state_next = W_RESULT;
            idx_next   = '0;
          end else begin
            idx_next      = idx_reg + IDX_W'(1);
            mem_addr_next = mem_addr_reg + ADDR_W'(1);
            state_next    = D_FETCH;
          end
        end
      end
      W_RESULT: begin
        if (rx_valid) begin
          result_next       = rx_byte;
          result_valid_next = 1'b1;
          state_next        = DONE;
        end else if (tmo_expired) begin
          state_next = ERR;
        end else begin
          tmo_next = tmo_reg + TMO_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Decoded from the state register so tx_start falls as soon as reset asserts.
  assign tx_start     = (state_reg == P_SEND) || (state_reg == D_SEND);
  assign busy         = !((state_reg == IDLE) || (state_reg == DONE) || (state_reg == ERR));
  assign done         = (state_reg == DONE);
  assign error        = (state_reg == ERR);
  assign tx_byte      = tx_byte_reg;
  assign mem_addr     = mem_addr_reg;
  assign result       = result_reg;
  assign result_valid = result_valid_reg;

endmodule
